phase_sequencer: RTL and testbench

- Parametrised successor to the top-level fixed input→action→display sequencer.
- Drives NUM_PHASES sub-blocks in round-robin order through a per-phase enable/done handshake.
- Adds a run/stop control, a per-phase skip mask, a round counter and an optional per-phase watchdog.
- Sits in the top level; sub-blocks (get_input, action, display and future blocks) connect one phase each.

---
 rtl/phase_sequencer_if.sv | 25 ++
 rtl/phase_sequencer.sv | 145 ++++++++++++++
 tb/tb_phase_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Handshake bundle between phase_sequencer (master) and the top level that owns the sub-blocks (slave).
interface phase_sequencer_if #(
   parameter int NUM_PHASES = 3,
   parameter int PH_W       = 4,
   parameter int ROUND_W    = 8
);
   logic                  run_i;
   logic [NUM_PHASES-1:0] skip_i;
   logic [NUM_PHASES-1:0] done_i;
   logic [NUM_PHASES-1:0] en_o;
   logic [PH_W-1:0]       phase_o;
   logic [ROUND_W-1:0]    round_o;
   logic                  idle_o;
   logic                  timeout_o;

   modport master (
      input  run_i, skip_i, done_i,
      output en_o, phase_o, round_o, idle_o, timeout_o
   );

   modport slave (
      output run_i, skip_i, done_i,
      input  en_o, phase_o, round_o, idle_o, timeout_o
   );
endinterface

// File: rtl/phase_sequencer.sv
// Round-robin enable/done sequencer for NUM_PHASES sub-blocks with run/stop, skip mask and round counter.
// Optional per-phase watchdog is built only when PHASE_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | stopped, en_o low, waiting for run_i
//   ARM   | enable current phase (unless skipped); done_i ignored
//   WAIT  | enable held until done_i[phase] (or watchdog expiry)
//   NEXT  | advance phase, or close the round and restart / stop
module phase_sequencer #(
   parameter int NUM_PHASES     = 3,
   parameter int PH_W           = 4,
   parameter int ROUND_W        = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input logic              clk,
   input logic              rst_n,
   phase_sequencer_if.master bus
);

   typedef enum logic [1:0] {IDLE, ARM, WAIT, NEXT} state_t;

   localparam int                    LAST_IDX   = NUM_PHASES - 1;
   localparam logic [PH_W-1:0]       LAST_PHASE = LAST_IDX[PH_W-1:0];
   localparam logic [NUM_PHASES-1:0] PHASE_ONE  = {{(NUM_PHASES-1){1'b0}}, 1'b1};

   if (NUM_PHASES < 2 || NUM_PHASES > 16) begin : g_bad_num_phases
      $error("phase_sequencer: NUM_PHASES must be 2..16");
   end
   if ((1 << PH_W) < NUM_PHASES) begin : g_bad_ph_w
      $error("phase_sequencer: PH_W too narrow for NUM_PHASES");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("phase_sequencer: TIMEOUT_CYCLES must be 1..65535");
   end

   state_t                state_q, state_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic [ROUND_W-1:0]    round_q, round_d;
   logic                  skip_q, skip_d;
   logic [NUM_PHASES-1:0] phase_sel;
   logic                  done_hit;

`ifdef PHASE_TIMEOUT_EN
   localparam logic [15:0] WDOG_LIMIT = TIMEOUT_CYCLES[15:0];
   logic [15:0] wdog_q, wdog_d;
   logic        timeout_q, timeout_d;
`endif

   // Mask-and-reduce keeps the select width-safe when PH_W exceeds the index range.
   assign phase_sel = PHASE_ONE << phase_q;
   assign done_hit  = |(bus.done_i & phase_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         round_q   <= '0;
         skip_q    <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
         wdog_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         round_q   <= round_d;
         skip_q    <= skip_d;
`ifdef PHASE_TIMEOUT_EN
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      round_d   = round_q;
      skip_d    = skip_q;
`ifdef PHASE_TIMEOUT_EN
      wdog_d    = wdog_q;
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.run_i) begin
               state_d = ARM;
               phase_d = '0;
            end
         end
         ARM: begin
            state_d = skip_q ? NEXT : WAIT;
`ifdef PHASE_TIMEOUT_EN
            wdog_d  = '0;
`endif
         end
         WAIT: begin
`ifdef PHASE_TIMEOUT_EN
            wdog_d = wdog_q + 16'd1;
`endif
            // done takes priority over a coincident watchdog expiry
            if (done_hit) begin
               state_d = NEXT;
            end
`ifdef PHASE_TIMEOUT_EN
            else if (wdog_d == WDOG_LIMIT) begin
               state_d   = NEXT;
               timeout_d = 1'b1;
            end
`endif
         end
         NEXT: begin
            if (phase_q != LAST_PHASE) begin
               phase_d = phase_q + 1'b1;
               state_d = ARM;
            end else begin
               round_d = round_q + 1'b1;
               if (bus.run_i) begin
                  phase_d = '0;
                  state_d = ARM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Skip flag is latched on ARM entry so en_o never depends on skip_i combinationally.
      if (state_d == ARM) begin
         skip_d = |(bus.skip_i & (PHASE_ONE << phase_d));
      end
   end

   assign bus.en_o    = ((state_q == WAIT) || (state_q == ARM && !skip_q)) ? phase_sel : '0;
   assign bus.phase_o = phase_q;
   assign bus.round_o = round_q;
   assign bus.idle_o  = (state_q == IDLE);
`ifdef PHASE_TIMEOUT_EN
   assign bus.timeout_o = timeout_q;
`else
   assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: table of single rounds plus hand sequences, visits checked against a scoreboard queue.
module tb_phase_sequencer;
   localparam int NP  = 3;
   localparam int PW  = 4;
   localparam int RW  = 2;
   localparam int TMO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   phase_sequencer_if #(.NUM_PHASES(NP), .PH_W(PW), .ROUND_W(RW)) bus ();

   phase_sequencer #(
      .NUM_PHASES(NP), .PH_W(PW), .ROUND_W(RW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      int phase;
      int en_w;
      int len;
      int rnd;
      int tmo;
   } visit_t;

   typedef struct {
      logic [NP-1:0] skip;
      int            dly[NP];
      int            en_w[NP];
   } vec_t;

   visit_t        sb[$];
   vec_t          vecs[6];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            round_exp = 0;
   int            idle_bad = 0;
   int            dly[NP];
   int            ecnt[NP];
   logic [NP-1:0] stale_done = '0;
   logic [NP-1:0] resp_done  = '0;

   assign bus.done_i = resp_done | stale_done;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [NP-1:0] s, input int d0, input int d1, input int d2,
                               input int w0, input int w1, input int w2);
      vec_t v;
      v.skip    = s;
      v.dly[0]  = d0; v.dly[1]  = d1; v.dly[2]  = d2;
      v.en_w[0] = w0; v.en_w[1] = w1; v.en_w[2] = w2;
      return v;
   endfunction

   // Skipped phase = ARM + NEXT; served phase = en_w enable cycles + NEXT.
   task automatic push_visit(input int p, input int en_w, input int tmo);
      visit_t v;
      v.phase = p;
      v.en_w  = en_w;
      v.len   = (en_w == 0) ? 2 : en_w + 1;
      if (p == NP - 1) round_exp = (round_exp + 1) % (1 << RW);
      v.rnd = round_exp;
      v.tmo = tmo;
      sb.push_back(v);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while ((sb.size() != 0 || !bus.idle_o) && k < budget) begin
         tick();
         k++;
      end
      check({name, "_drained"}, int'(sb.size() == 0 && bus.idle_o == 1'b1), 1);
      sb.delete();
   endtask

   // Sub-block model: done pulses for one cycle once en has been high dly[p] cycles (0 = never).
   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (bus.en_o[p]) ecnt[p] = ecnt[p] + 1;
         else             ecnt[p] = 0;
         resp_done[p] = (dly[p] != 0 && ecnt[p] == dly[p]);
      end
   end

   bit            in_visit = 1'b0;
   int            cur_phase, v_len, v_en, v_tmo, v_bad;
   logic [NP-1:0] oh;
   visit_t        mon_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_visit = 1'b0;
      end else begin
         if (bus.idle_o && (bus.en_o != '0 || bus.timeout_o)) idle_bad++;
         if (in_visit && (bus.idle_o || int'(bus.phase_o) != cur_phase)) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_visit: got phase %0d, expected no visit", cur_phase);
            end else begin
               mon_exp = sb.pop_front();
               check("visit_phase", cur_phase, mon_exp.phase);
               check($sformatf("p%0d_en_width", mon_exp.phase), v_en, mon_exp.en_w);
               check($sformatf("p%0d_visit_len", mon_exp.phase), v_len, mon_exp.len);
               check($sformatf("p%0d_round", mon_exp.phase), int'(bus.round_o), mon_exp.rnd);
               check($sformatf("p%0d_timeout_pulses", mon_exp.phase), v_tmo, mon_exp.tmo);
               check($sformatf("p%0d_en_onehot", mon_exp.phase), v_bad, 0);
            end
            in_visit = 1'b0;
         end
         if (!bus.idle_o && !in_visit) begin
            in_visit  = 1'b1;
            cur_phase = int'(bus.phase_o);
            v_len = 0; v_en = 0; v_tmo = 0; v_bad = 0;
         end
         if (in_visit) begin
            oh = '0;
            oh[cur_phase] = 1'b1;
            v_len++;
            if (bus.en_o == oh)       v_en++;
            else if (bus.en_o != '0)  v_bad = 1;
            if (bus.timeout_o)        v_tmo++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int k;
      bus.run_i  = 1'b0;
      bus.skip_i = '0;
      dly        = '{3, 3, 3};

      vecs[0] = mk(3'b000, 3, 3, 3, 3, 3, 3);
      vecs[1] = mk(3'b010, 3, 3, 3, 3, 0, 3);
      vecs[2] = mk(3'b111, 2, 2, 2, 0, 0, 0);
      vecs[3] = mk(3'b101, 5, 5, 5, 0, 5, 0);
      vecs[4] = mk(3'b000, 2, 4, 6, 2, 4, 6);
      vecs[5] = mk(3'b100, 4, 2, 3, 4, 2, 0);

      // async reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("reset_idle",    int'(bus.idle_o),    1);
      check("reset_en",      int'(bus.en_o),      0);
      check("reset_phase",   int'(bus.phase_o),   0);
      check("reset_round",   int'(bus.round_o),   0);
      check("reset_timeout", int'(bus.timeout_o), 0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         tick();
         bus.skip_i = vecs[i].skip;
         dly        = vecs[i].dly;
         for (int p = 0; p < NP; p++) push_visit(p, vecs[i].en_w[p], 0);
         bus.run_i = 1'b1;
         tick();
         bus.run_i = 1'b0;
         drain($sformatf("vec%0d", i), 80);
      end

      // stop mid-round with a stale done held on phase 0
      tick();
      bus.skip_i = '0;
      dly        = '{3, 3, 3};
      stale_done = 3'b001;
      push_visit(0, 2, 0);
      push_visit(1, 3, 0);
      push_visit(2, 3, 0);
      bus.run_i = 1'b1;
      k = 0;
      while (!(bus.phase_o == 4'd1 && !bus.idle_o) && k < 40) begin
         tick();
         k++;
      end
      check("stop_reached_p1", int'(bus.phase_o), 1);
      bus.run_i = 1'b0;
      drain("stop", 60);
      repeat (4) tick();
      check("stop_idle",  int'(bus.idle_o),  1);
      check("stop_en",    int'(bus.en_o),    0);
      check("stop_phase", int'(bus.phase_o), NP - 1);
      check("stop_round", int'(bus.round_o), round_exp);
      stale_done = '0;

      // reset while phase 2 is in WAIT
      tick();
      dly = '{3, 3, 0};
      push_visit(0, 3, 0);
      push_visit(1, 3, 0);
      bus.run_i = 1'b1;
      k = 0;
      while (!(bus.phase_o == 4'd2 && bus.en_o[2]) && k < 40) begin
         tick();
         k++;
      end
      tick();
      tick();
      check("rst_wait_en_before", int'(bus.en_o), 4);
      check("rst_wait_visits_done", sb.size(), 0);
      rst_n = 1'b0;
      #1;
      check("rst_wait_en",    int'(bus.en_o),    0);
      check("rst_wait_round", int'(bus.round_o), 0);
      check("rst_wait_phase", int'(bus.phase_o), 0);
      check("rst_wait_idle",  int'(bus.idle_o),  1);
      round_exp = 0;
      bus.run_i = 1'b0;
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // five back-to-back rounds, round_o wraps at 2 bits
      dly = '{2, 2, 2};
      for (int r = 0; r < 5; r++)
         for (int p = 0; p < NP; p++) push_visit(p, 2, 0);
      bus.run_i = 1'b1;
      k = 0;
      while (sb.size() > 1 && k < 200) begin
         tick();
         k++;
      end
      check("wrap_reached_last", int'(sb.size() <= 1), 1);
      bus.run_i = 1'b0;
      drain("wrap", 40);
      check("wrap_final_round", int'(bus.round_o), 1);

`ifdef PHASE_TIMEOUT_EN
      // phase 0 never answers: forced advance after TMO WAIT cycles
      tick();
      dly = '{0, 2, 2};
      push_visit(0, TMO + 1, 1);
      push_visit(1, 2, 0);
      push_visit(2, 2, 0);
      bus.run_i = 1'b1;
      tick();
      bus.run_i = 1'b0;
      drain("timeout", 80);

      // done arrives in the same cycle the watchdog expires
      tick();
      dly = '{TMO + 1, 2, 2};
      push_visit(0, TMO + 1, 0);
      push_visit(1, 2, 0);
      push_visit(2, 2, 0);
      bus.run_i = 1'b1;
      tick();
      bus.run_i = 1'b0;
      drain("timeout_tie", 80);
`endif

      check("idle_quiet", idle_bad, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
